// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: debounces the start/stop, lap and clear buttons,
// runs the IDLE/RUN/PAUSE/LAP state machine, and drives the BCD counter
// with enable, a prescaled count tick, a clear pulse and a display hold.
module stopwatch_ctrl #(
   parameter int TICK_DIV   = 500000,
   parameter int DEB_CYCLES = 250000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic       btn_ss,
   input  logic       btn_lap,
   input  logic       btn_clr,
   output logic       cnt_enable,
   output logic       cnt_tick,
   output logic       cnt_clear,
   output logic       disp_hold,
   output logic [1:0] state
);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      RUN   = 2'b01,
      PAUSE = 2'b10,
      LAP   = 2'b11
   } state_t;

   localparam int PW = $clog2(TICK_DIV);
   localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
   localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
   localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);

   // Button vectors are ordered {clr, lap, ss}.
   logic [2:0]    btn_raw;
   logic [2:0]    sync1_p0;
   logic [2:0]    sync2_p0;
   logic [DW-1:0] deb_cnt [3];
   logic [2:0]    db;
   logic [2:0]    db_d;
   logic [2:0]    press;
   logic [2:0]    press_p1;
   logic          ev_ss_p2;
   logic          ev_lap_p2;
   logic          ev_clr_p2;
   state_t        st;
   logic [PW-1:0] pre_cnt;

   assign btn_raw = {btn_clr, btn_lap, btn_ss};

   // Two-flop synchronizer for the asynchronous button inputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_p0 <= '0;
         sync2_p0 <= '0;
      end else begin
         sync1_p0 <= btn_raw;
         sync2_p0 <= sync1_p0;
      end
   end

   // Debounce: accept a new level only after DEB_CYCLES consecutive differing samples.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 3; i++) deb_cnt[i] <= '0;
         db   <= '0;
         db_d <= '0;
      end else begin
         db_d <= db;
         for (int i = 0; i < 3; i++) begin
            if (sync2_p0[i] == db[i]) begin
               deb_cnt[i] <= '0;
            end else if (deb_cnt[i] == DEB_LAST) begin
               db[i]      <= sync2_p0[i];
               deb_cnt[i] <= '0;
            end else begin
               deb_cnt[i] <= deb_cnt[i] + DW'(1);
            end
         end
      end
   end

   // Rising edge of the debounced level; releases give nothing.
   assign press = db & ~db_d;

   // Register press pulses, then gate with en and resolve priority clr > ss > lap.
   always_ff @(posedge clk) begin
      if (rst) begin
         press_p1  <= '0;
         ev_clr_p2 <= 1'b0;
         ev_ss_p2  <= 1'b0;
         ev_lap_p2 <= 1'b0;
      end else begin
         // stage p1: press pulse
         press_p1  <= press;
         // stage p2: gated, prioritised event
         ev_clr_p2 <= en & press_p1[2];
         ev_ss_p2  <= en & press_p1[0] & ~press_p1[2];
         ev_lap_p2 <= en & press_p1[1] & ~press_p1[0] & ~press_p1[2];
      end
   end

   // Main state machine; cnt_clear is a one-cycle registered pulse on a taken clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         st        <= IDLE;
         cnt_clear <= 1'b0;
      end else begin
         cnt_clear <= 1'b0;
         case (st)
            IDLE: begin
               if (ev_clr_p2)     cnt_clear <= 1'b1;
               else if (ev_ss_p2) st <= RUN;
            end
            RUN: begin
               if (ev_ss_p2)       st <= PAUSE;
               else if (ev_lap_p2) st <= LAP;
            end
            LAP: begin
               if (ev_ss_p2)       st <= PAUSE;
               else if (ev_lap_p2) st <= RUN;
            end
            PAUSE: begin
               if (ev_clr_p2) begin
                  st        <= IDLE;
                  cnt_clear <= 1'b1;
               end else if (ev_ss_p2) begin
                  st <= RUN;
               end
            end
            default: st <= IDLE;
         endcase
      end
   end

   // Tick prescaler: runs while enabled, holds in PAUSE, zeroed in IDLE or on clear.
   // A wrap on the edge that leaves RUN/LAP (ss taken) issues no tick.
   always_ff @(posedge clk) begin
      if (rst) begin
         pre_cnt  <= '0;
         cnt_tick <= 1'b0;
      end else begin
         cnt_tick <= 1'b0;
         if (st == IDLE || cnt_clear) begin
            pre_cnt <= '0;
         end else if (cnt_enable) begin
            if (pre_cnt == PRE_LAST) begin
               pre_cnt  <= '0;
               cnt_tick <= ~ev_ss_p2;
            end else begin
               pre_cnt <= pre_cnt + PW'(1);
            end
         end
      end
   end

   assign cnt_enable = st[0];
   assign disp_hold  = (st == LAP);
   assign state      = st;

endmodule
